// File: rtl/cla_seq_adder.sv
// Multi-cycle adder: one CHUNK-wide carry-lookahead slice reused LSB chunk first.
// Result valid CHUNKS cycles after accept; held stable until out_ready, in_ready low while busy.

module cla_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  localparam int NG = W / 4;

  logic [W-1:0]  p;
  logic [W-1:0]  g;
  logic [W-1:0]  c;
  logic [NG-1:0] grp_p;
  logic [NG-1:0] grp_g;
  logic [NG:0]   gc;
  logic          term;

  always_comb begin
    p     = a ^ b;
    g     = a & b;
    c     = '0;
    grp_p = '0;
    grp_g = '0;
    gc    = '0;
    term  = 1'b0;

    for (int j = 0; j < NG; j++) begin
      grp_p[j] = &p[4*j +: 4];
      grp_g[j] = g[4*j+3]
               | (p[4*j+3] & g[4*j+2])
               | (p[4*j+3] & p[4*j+2] & g[4*j+1])
               | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
    end

    // Second level: every group carry is a flat sum-of-products, no group-to-group ripple.
    for (int j = 0; j <= NG; j++) begin
      gc[j] = ci;
      for (int k = 0; k < j; k++) begin
        gc[j] = gc[j] & grp_p[k];
      end
      for (int i = 0; i < j; i++) begin
        term = grp_g[i];
        for (int k = i + 1; k < j; k++) begin
          term = term & grp_p[k];
        end
        gc[j] = gc[j] | term;
      end
    end

    for (int j = 0; j < NG; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1]
               | (p[4*j+1] & g[4*j])
               | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2]
               | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end

    s  = p ^ c;
    co = gc[NG];
  end

endmodule

module cla_seq_adder #(
  parameter int OP_WIDTH = 32,
  parameter int CHUNK    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OP_WIDTH-1:0] a,
  input  logic [OP_WIDTH-1:0] b,
  input  logic                cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OP_WIDTH-1:0] sum,
  output logic                cout,
  output logic                busy
);

  localparam int CHUNKS = OP_WIDTH / CHUNK;
  localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [OP_WIDTH-1:0] a_q, a_d;
  logic [OP_WIDTH-1:0] b_q, b_d;
  logic [OP_WIDTH-1:0] sum_q, sum_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                carry_q, carry_d;
  logic                cout_q, cout_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;

  logic [CHUNK-1:0]    slice_a;
  logic [CHUNK-1:0]    slice_b;
  logic [CHUNK-1:0]    slice_s;
  logic                slice_co;

  always_comb begin
    slice_a = a_q[int'(idx_q)*CHUNK +: CHUNK];
    slice_b = b_q[int'(idx_q)*CHUNK +: CHUNK];
  end

  cla_slice #(
    .W (CHUNK)
  ) u_cla (
    .a  (slice_a),
    .b  (slice_b),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
          carry_d = cin;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[int'(idx_q)*CHUNK +: CHUNK] = slice_s;
        carry_d = slice_co;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          cout_d  = slice_co;
          state_d = DONE;
        end
      end
      DONE: begin
        // Returning to IDLE here means a new request cannot land on the handshake edge.
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign busy      = busy_q;

endmodule
